// File: rtl/fetch_controller.sv
// Fetch controller with 2-entry prefetch buffer; optional misaligned-redirect fault via FETCH_ALIGN_CHECK_EN.
// Redirect -> first instruction in 2 cycles; fetch stalls when full with no pop.
module fetch_controller #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic        fault,
   output logic [31:0] fault_pc
);

   localparam logic [1:0] FULL = 2'(BUF_DEPTH);

   typedef enum logic {RUN, FAULT} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [1:0]  count_q, count_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic [31:0] pc_q  [2];
   logic [31:0] dat_q [2];
   logic        enq;
   logic        pop;
   logic        misaligned;
   logic [31:0] target;

`ifdef FETCH_ALIGN_CHECK_EN
   logic [31:0] fault_pc_q, fault_pc_d;

   assign misaligned = |redirect_pc[1:0];
   assign target     = redirect_pc;
   assign fault      = (state_q == FAULT);
   assign fault_pc   = fault_pc_q;
`else
   // Low bits are dropped so a misaligned target fetches its containing word.
   assign misaligned = 1'b0;
   assign target     = {redirect_pc[31:2], 2'b00};
   assign fault      = 1'b0;
   assign fault_pc   = 32'h0000_0000;
`endif

   assign pop        = (count_q != 2'd0) && inst_ready;
   assign imem_addr  = fetch_pc_q;
   assign inst_valid = (count_q != 2'd0);
   assign inst_data  = dat_q[rd_ptr_q];
   assign inst_pc    = pc_q[rd_ptr_q];

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      enq        = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_pc_d = fault_pc_q;
`endif
      if (redirect_valid) begin
         // Redirect wins over a same-cycle pop: the whole buffer is dropped.
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         if (misaligned) begin
            state_d = FAULT;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_pc_d = redirect_pc;
`endif
         end else begin
            state_d    = RUN;
            fetch_pc_d = target;
         end
      end else if (state_q == RUN) begin
         enq = (count_q != FULL) || pop;
         if (pop) rd_ptr_d = ~rd_ptr_q;
         if (enq) begin
            wr_ptr_d   = ~wr_ptr_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (enq && !pop)      count_d = count_q + 2'd1;
         else if (pop && !enq) count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         count_q    <= 2'd0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         pc_q[0]    <= 32'h0;
         pc_q[1]    <= 32'h0;
         dat_q[0]   <= 32'h0;
         dat_q[1]   <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
         fault_pc_q <= 32'h0;
`endif
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         if (enq) begin
            pc_q[wr_ptr_q]  <= fetch_pc_q;
            dat_q[wr_ptr_q] <= imem_rdata;
         end
`ifdef FETCH_ALIGN_CHECK_EN
         fault_pc_q <= fault_pc_d;
`endif
      end
   end

endmodule
